barrel_launcher: RTL and testbench

Donkey-side barrel dispatcher: the initiator end of the `barrel`/`done` handshake consumed by the horizontal barrel movers. Owns a pool of `N_BARRELS` mover instances, tracks which are in flight, waits a jittered interval between throws, raises a throw-animation flag for the donkey sprite, then fires a one-cycle launch pulse into the lowest free mover. Sits between game control (`enable`) and the array of barrel movers.

---
 rtl/barrel_launcher.sv | 125 ++++++++++++
 tb/tb_barrel_launcher.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_launcher.sv
// Donkey-side barrel dispatcher: paces throws with a jittered interval and
// fires a one-cycle launch pulse into the lowest free barrel mover.
module barrel_launcher #(
    parameter int          N_BARRELS     = 4,
    parameter logic [23:0] BASE_INTERVAL = 24'd2_000_000,
    parameter int          JITTER_BITS   = 4,
    parameter int          JITTER_SHIFT  = 16,
    parameter logic [23:0] THROW_CYCLES  = 24'd500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_BARRELS-1:0] done,
    output logic [N_BARRELS-1:0] barrel,
    output logic [N_BARRELS-1:0] busy,
    output logic                 throw,
    output logic [7:0]           launched_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_THROW,
        ST_LAUNCH
    } state_t;

    localparam logic [15:0] JMASK = 16'((32'd1 << JITTER_BITS) - 32'd1);
    localparam logic [N_BARRELS-1:0] ONE = 1;

    state_t      state, state_nx;
    logic [23:0] cnt, cnt_nx;
    logic [2:0]  slot;
    logic [2:0]  free_idx;
    logic        any_free;
    logic        slot_ld;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [23:0] interval;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign interval = BASE_INTERVAL + (24'(lfsr & JMASK) << JITTER_SHIFT);

    assign throw  = (state == ST_THROW);
    assign barrel = (state == ST_LAUNCH) ? (ONE << slot) : '0;

    // Lowest-index free slot wins.
    always_comb begin
        free_idx = 3'd0;
        any_free = 1'b0;
        for (int i = N_BARRELS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = 3'(i);
                any_free = 1'b1;
            end
        end
    end

    // Counters hold "cycles left minus one" so a zero means this is the last cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        slot_ld  = 1'b0;
        if (!enable) begin
            state_nx = ST_IDLE;
            cnt_nx   = 24'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nx = ST_WAIT;
                    cnt_nx   = interval - 24'd1;
                end
                ST_WAIT: begin
                    if (cnt != 24'd0) begin
                        cnt_nx = cnt - 24'd1;
                    end else if (any_free) begin
                        state_nx = ST_THROW;
                        cnt_nx   = THROW_CYCLES - 24'd1;
                        slot_ld  = 1'b1;
                    end
                end
                ST_THROW: begin
                    if (cnt != 24'd0) begin
                        cnt_nx = cnt - 24'd1;
                    end else begin
                        state_nx = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_nx = ST_WAIT;
                    cnt_nx   = interval - 24'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 24'd0;
            slot  <= 3'd0;
            lfsr  <= 16'hACE1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lfsr  <= {lfsr[14:0], lfsr_fb};
            if (slot_ld) begin
                slot <= free_idx;
            end
        end
    end

    // A pulse already emitted must be accounted for even if enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy           <= '0;
            launched_count <= 8'd0;
        end else begin
            busy <= (busy & ~done) | barrel;
            if (state == ST_LAUNCH) begin
                launched_count <= launched_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_barrel_launcher.sv
// Bench for barrel_launcher: a deterministic and a jittered instance run side
// by side against a timeline reference model.
module tb_barrel_launcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_j;
    logic [3:0] dn_a, dn_j;
    logic [3:0] barrel_a, busy_a, barrel_j, busy_j;
    logic       throw_a, throw_j;
    logic [7:0] cnt_a, cnt_j;

    always #5 clk = ~clk;

    barrel_launcher #(
        .N_BARRELS(4), .BASE_INTERVAL(24'd10), .JITTER_BITS(0),
        .JITTER_SHIFT(0), .THROW_CYCLES(24'd3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .done(dn_a),
        .barrel(barrel_a), .busy(busy_a), .throw(throw_a),
        .launched_count(cnt_a)
    );

    barrel_launcher #(
        .N_BARRELS(4), .BASE_INTERVAL(24'd12), .JITTER_BITS(4),
        .JITTER_SHIFT(0), .THROW_CYCLES(24'd2)
    ) dut_j (
        .clk(clk), .rst_n(rst_n), .enable(en_j), .done(dn_j),
        .barrel(barrel_j), .busy(busy_j), .throw(throw_j),
        .launched_count(cnt_j)
    );

    localparam int PB [2] = '{10, 12};
    localparam int PT [2] = '{3, 2};
    localparam int PJ [2] = '{0, 15};

    int n_chk = 0;
    int n_err = 0;

    // Timeline model: cycle WAIT began, its length, throw start, launch cycle.
    int          m_t0 [2];
    int          m_i  [2];
    int          m_ts [2];
    int          m_la [2];
    int          m_slot [2];
    int          m_ll [2];
    int          m_lslot [2];
    bit          m_run [2];
    logic [3:0]  m_busy [2];
    logic [7:0]  m_cnt [2];
    logic [15:0] m_lfsr;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int lowest_free(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (!b[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d]   = 1'b0;
            m_t0[d]    = 0;
            m_i[d]     = 0;
            m_ts[d]    = -1;
            m_la[d]    = -1;
            m_slot[d]  = 0;
            m_ll[d]    = -10;
            m_lslot[d] = 0;
            m_busy[d]  = 4'd0;
            m_cnt[d]   = 8'd0;
        end
        m_lfsr = 16'hACE1;
        cyc    = -1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".a.barrel"}, 32'(barrel_a), 32'd0);
        chk({tag, ".a.busy"}, 32'(busy_a), 32'd0);
        chk({tag, ".a.throw"}, 32'(throw_a), 32'd0);
        chk({tag, ".a.count"}, 32'(cnt_a), 32'd0);
        chk({tag, ".j.barrel"}, 32'(barrel_j), 32'd0);
        chk({tag, ".j.busy"}, 32'(busy_j), 32'd0);
        chk({tag, ".j.throw"}, 32'(throw_j), 32'd0);
        chk({tag, ".j.count"}, 32'(cnt_j), 32'd0);
    endtask

    // Advance one clock, update the model with the inputs held over the
    // previous cycle, then compare both instances.
    task automatic step();
        logic        en [2];
        logic [3:0]  dn [2];
        logic [15:0] lp;
        logic [3:0]  bp;
        logic [3:0]  eb;
        logic        et;
        en[0] = en_a;
        en[1] = en_j;
        dn[0] = dn_a;
        dn[1] = dn_j;
        @(negedge clk);
        cyc++;
        lp     = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        for (int d = 0; d < 2; d++) begin
            bp        = m_busy[d];
            m_busy[d] = bp & ~dn[d];
            if (m_run[d] && m_la[d] == cyc - 1) begin
                m_busy[d]  = m_busy[d] | (4'b0001 << m_slot[d]);
                m_cnt[d]   = m_cnt[d] + 8'd1;
                m_ll[d]    = cyc - 1;
                m_lslot[d] = m_slot[d];
            end
            if (!en[d]) begin
                m_run[d] = 1'b0;
                m_ts[d]  = -1;
                m_la[d]  = -1;
            end else if (!m_run[d] || m_la[d] == cyc - 1) begin
                m_run[d] = 1'b1;
                m_t0[d]  = cyc;
                m_i[d]   = PB[d] + int'(lp & 16'(PJ[d]));
                m_ts[d]  = -1;
                m_la[d]  = -1;
            end else if (m_ts[d] < 0 && cyc - 1 >= m_t0[d] + m_i[d] - 1
                         && bp != 4'hF) begin
                m_ts[d]   = cyc;
                m_slot[d] = lowest_free(bp);
                m_la[d]   = cyc + PT[d];
            end
            et = m_run[d] && m_ts[d] >= 0 && cyc >= m_ts[d] && cyc < m_la[d];
            eb = (m_run[d] && cyc == m_la[d]) ? (4'b0001 << m_slot[d]) : 4'd0;
            chk($sformatf("d%0d.barrel@%0d", d, cyc),
                32'(d == 0 ? barrel_a : barrel_j), 32'(eb));
            chk($sformatf("d%0d.throw@%0d", d, cyc),
                32'(d == 0 ? throw_a : throw_j), 32'(et));
            chk($sformatf("d%0d.busy@%0d", d, cyc),
                32'(d == 0 ? busy_a : busy_j), 32'(m_busy[d]));
            chk($sformatf("d%0d.count@%0d", d, cyc),
                32'(d == 0 ? cnt_a : cnt_j), 32'(m_cnt[d]));
        end
    endtask

    function automatic logic [3:0] auto_done(input int d);
        return (m_ll[d] == cyc - 1) ? (4'b0001 << m_lslot[d]) : 4'd0;
    endfunction

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_j  = 1'b0;
        dn_a  = 4'd0;
        dn_j  = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");

        rst_n = 1'b1;
        en_a  = 1'b1;
        en_j  = 1'b1;
        for (int k = 0; k < 140; k++) begin
            step();
            dn_a = 4'd0;
            if (cyc == 30)  dn_a = 4'b0100;
            if (cyc == 100) dn_a = 4'b0010;
            if (cyc == 110) dn_a = 4'b0001;
            en_a = !(cyc >= 117 && cyc < 125);
            dn_j = auto_done(1);
        end

        // cycle 139 is a launch cycle for instance a
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        check_zero("rst_hold");

        rst_n = 1'b1;
        en_a  = 1'b1;
        en_j  = 1'b1;
        dn_a  = 4'd0;
        dn_j  = 4'd0;
        for (int k = 0; k < 500; k++) begin
            step();
            dn_a = auto_done(0);
            dn_j = auto_done(1);
            if ($urandom_range(0, 7) == 0) dn_j = dn_j | 4'($urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
